// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master: START, addr+R/W, one data byte, STOP.
// Open-drain scl/sda; valid/ready command port, one-cycle response pulse.
//
// Parameters:
//   DIV        clk cycles per SCL quarter-period (SCL = clk/(4*DIV)), >= 4
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  high in IDLE; accept on cmd_valid && cmd_ready
//   cmd_addr   7-bit target address
//   cmd_rw     0 = write cmd_wdata, 1 = read one byte
//   cmd_wdata  write byte, sent MSB first
//   rsp_valid  one-cycle pulse when the transaction finishes
//   rsp_rdata  read byte (0 for writes and address NACK)
//   rsp_nack   address or write-data NACK seen
//   busy       transaction in progress
//   scl, sda   open-drain bus lines (driven 0 or released)

module i2c_master_ctrl #(
    parameter int DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] ADDR  = 4'd2;
    localparam logic [3:0] AACK  = 4'd3;
    localparam logic [3:0] WDATA = 4'd4;
    localparam logic [3:0] WACK  = 4'd5;
    localparam logic [3:0] RDATA = 4'd6;
    localparam logic [3:0] RNACK = 4'd7;
    localparam logic [3:0] STOP  = 4'd8;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic [7:0]    wdata_r;
    logic          rw_r;
    logic          nack_r;
    logic          sda_m;
    logic          sda_s;
    logic          q_end;
    logic          bit_end;
    logic          scl_low;
    logic          sda_low;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign q_end   = (cnt == CW'(DIV - 1));
    assign bit_end = q_end && (q == 2'd3);

    // Line drive is decoded straight from state so an async reset
    // releases both lines without waiting for a clock edge.
    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_m <= 1'b1;
            sda_s <= 1'b1;
        end else begin
            sda_m <= sda;
            sda_s <= sda_m;
        end
    end

    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state)
            IDLE: begin
            end
            START: begin
                sda_low = q[1];
            end
            ADDR, WDATA: begin
                scl_low = !q[1];
                sda_low = !tx_sh[7];
            end
            AACK, WACK, RDATA, RNACK: begin
                scl_low = !q[1];
            end
            STOP: begin
                scl_low = !q[1];
                sda_low = (q != 2'd3);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            wdata_r   <= 8'h00;
            rw_r      <= 1'b0;
            nack_r    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                q   <= 2'd0;
                if (cmd_valid) begin
                    state   <= START;
                    tx_sh   <= {cmd_addr, cmd_rw};
                    wdata_r <= cmd_wdata;
                    rw_r    <= cmd_rw;
                    nack_r  <= 1'b0;
                    bit_cnt <= 3'd0;
                    rx_sh   <= 8'h00;
                end
            end else begin
                if (q_end) begin
                    cnt <= '0;
                    q   <= q + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // sda_s on the last clk of Q3 is the bit's sample.
                if (bit_end) begin
                    unique case (state)
                        START: begin
                            state <= ADDR;
                        end
                        ADDR: begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= AACK;
                            end
                        end
                        AACK: begin
                            if (sda_s) begin
                                nack_r <= 1'b1;
                                state  <= STOP;
                            end else if (rw_r) begin
                                state <= RDATA;
                            end else begin
                                tx_sh <= wdata_r;
                                state <= WDATA;
                            end
                        end
                        WDATA: begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= WACK;
                            end
                        end
                        WACK: begin
                            nack_r <= sda_s;
                            state  <= STOP;
                        end
                        RDATA: begin
                            rx_sh   <= {rx_sh[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RNACK;
                            end
                        end
                        RNACK: begin
                            state <= STOP;
                        end
                        STOP: begin
                            state     <= IDLE;
                            rsp_valid <= 1'b1;
                            rsp_nack  <= nack_r;
                            rsp_rdata <= (rw_r && !nack_r) ? rx_sh : 8'h00;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural slave at 0x50
// and a bus monitor counting START/STOP edges, SCL rises and period.

`timescale 1ns/1ns

module tb_i2c_master_ctrl;

    localparam int DIV = 8;

    localparam int S_IDLE = 0;
    localparam int S_ADDR = 1;
    localparam int S_AACK = 2;
    localparam int S_WR   = 3;
    localparam int S_WACK = 4;
    localparam int S_RD   = 5;
    localparam int S_RACK = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 clk = ~clk;

    // behavioural slave
    logic       s_attached = 1'b1;
    logic       s_send_valid = 1'b1;
    logic [7:0] s_data_out = 8'h00;
    logic [7:0] s_data_in;
    logic       s_oe;
    int         s_st;
    logic [3:0] s_bit;
    logic [7:0] s_sh;
    logic       s_rw;
    logic       s_scl_p;
    logic       s_sda_p;
    logic [7:0] s_tx;
    logic [2:0] s_idx;

    assign sda   = s_oe ? 1'b0 : 1'bz;
    assign s_tx  = s_send_valid ? s_data_out : 8'hFF;
    assign s_idx = 3'(4'd7 - s_bit);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_st      <= S_IDLE;
            s_oe      <= 1'b0;
            s_bit     <= 4'd0;
            s_sh      <= 8'h00;
            s_rw      <= 1'b0;
            s_scl_p   <= 1'b1;
            s_sda_p   <= 1'b1;
            s_data_in <= 8'h00;
        end else begin
            s_scl_p <= scl;
            s_sda_p <= sda;
            if (s_scl_p && scl && s_sda_p && !sda) begin
                s_st  <= S_ADDR;
                s_bit <= 4'd0;
                s_oe  <= 1'b0;
            end else if (s_scl_p && scl && !s_sda_p && sda) begin
                s_st <= S_IDLE;
                s_oe <= 1'b0;
            end else if (!s_scl_p && scl) begin
                if (s_st == S_ADDR || s_st == S_WR) begin
                    s_sh  <= {s_sh[6:0], sda};
                    s_bit <= s_bit + 4'd1;
                end else if (s_st == S_RD) begin
                    s_bit <= s_bit + 4'd1;
                end
            end else if (s_scl_p && !scl) begin
                case (s_st)
                    S_ADDR: if (s_bit == 4'd8) begin
                        if (s_attached && s_sh[7:1] == 7'h50) begin
                            s_rw <= s_sh[0];
                            s_oe <= 1'b1;
                            s_st <= S_AACK;
                        end else begin
                            s_st <= S_IDLE;
                        end
                    end
                    S_AACK: begin
                        s_bit <= 4'd0;
                        if (s_rw) begin
                            s_oe <= !s_tx[7];
                            s_st <= S_RD;
                        end else begin
                            s_oe <= 1'b0;
                            s_st <= S_WR;
                        end
                    end
                    S_WR: if (s_bit == 4'd8) begin
                        s_data_in <= s_sh;
                        s_oe      <= 1'b1;
                        s_st      <= S_WACK;
                    end
                    S_WACK: begin
                        s_oe <= 1'b0;
                        s_st <= S_IDLE;
                    end
                    S_RD: begin
                        if (s_bit == 4'd8) begin
                            s_oe <= 1'b0;
                            s_st <= S_RACK;
                        end else begin
                            s_oe <= !s_tx[s_idx];
                        end
                    end
                    S_RACK: s_st <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // bus monitor
    int   n_start = 0;
    int   n_stop = 0;
    int   n_rise = 0;
    int   n_rsp = 0;
    int   per_err = 0;
    int   cyc_n = 0;
    int   last_rise = -1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    always @(negedge clk) begin
        m_scl <= scl;
        m_sda <= sda;
        cyc_n <= cyc_n + 1;
        if (m_scl && scl && m_sda && !sda) n_start <= n_start + 1;
        if (m_scl && scl && !m_sda && sda) n_stop <= n_stop + 1;
        if (!m_scl && scl) n_rise <= n_rise + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if (rst || !busy) begin
            last_rise <= -1;
        end else if (!m_scl && scl) begin
            if (last_rise >= 0 && (cyc_n - last_rise) != 4 * DIV)
                per_err <= per_err + 1;
            last_rise <= cyc_n;
        end
    end

    int  n_chk = 0;
    int  n_fail = 0;
    time t_acc;
    int  lat;
    int  b_start, b_stop, b_rise, b_rsp;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_start = n_start;
        b_stop  = n_stop;
        b_rise  = n_rise;
        b_rsp   = n_rsp;
    endtask

    task automatic send(input logic [6:0] a, input logic rw,
                        input logic [7:0] d);
        @(negedge clk);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = -1;
        for (int i = 0; i < 200 * DIV; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                l = int'(($time - t_acc - 5) / 10);
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (3 * DIV) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 1);
        check("rst_sda", 32'(sda), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_nack", 32'(rsp_nack), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write 0xA5, with a cmd_valid pulse while busy
        snap();
        send(7'h50, 1'b0, 8'hA5);
        repeat (100) @(negedge clk);
        cmd_addr  = 7'h33;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t1_busy_mid", 32'(busy), 1);
        wait_rsp(lat);
        check("t1_latency", 32'(lat), 80 * DIV);
        check("t1_nack", 32'(rsp_nack), 0);
        check("t1_rdata", 32'(rsp_rdata), 0);
        check("t1_ready_at_rsp", 32'(cmd_ready), 1);
        @(negedge clk);
        check("t1_rsp_pulse", 32'(rsp_valid), 0);
        settle();
        check("t1_slave_data", 32'(s_data_in), 32'h A5);
        check("t1_starts", 32'(n_start - b_start), 1);
        check("t1_stops", 32'(n_stop - b_stop), 1);
        check("t1_scl_rises", 32'(n_rise - b_rise), 19);
        check("t1_rsp_count", 32'(n_rsp - b_rsp), 1);
        check("t1_busy_after", 32'(busy), 0);

        // 2: read 0x3C
        s_data_out = 8'h3C;
        snap();
        send(7'h50, 1'b1, 8'h00);
        wait_rsp(lat);
        check("t2_latency", 32'(lat), 80 * DIV);
        check("t2_rdata", 32'(rsp_rdata), 32'h3C);
        check("t2_nack", 32'(rsp_nack), 0);
        @(negedge clk);
        check("t2_rdata_held", 32'(rsp_rdata), 32'h3C);
        settle();
        check("t2_starts", 32'(n_start - b_start), 1);
        check("t2_stops", 32'(n_stop - b_stop), 1);

        // 3: address NACK with no slave
        s_attached = 1'b0;
        snap();
        send(7'h22, 1'b0, 8'hFF);
        wait_rsp(lat);
        check("t3_latency", 32'(lat), 44 * DIV);
        check("t3_nack", 32'(rsp_nack), 1);
        check("t3_rdata", 32'(rsp_rdata), 0);
        settle();
        check("t3_scl_rises", 32'(n_rise - b_rise), 10);
        check("t3_stops", 32'(n_stop - b_stop), 1);
        s_attached = 1'b1;

        // 4: back-to-back writes with cmd_valid held
        snap();
        @(negedge clk);
        cmd_addr  = 7'h50;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h11;
        cmd_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        wait_rsp(lat);
        check("t4_latency1", 32'(lat), 80 * DIV);
        check("t4_nack1", 32'(rsp_nack), 0);
        check("t4_ready_at_rsp", 32'(cmd_ready), 1);
        cmd_wdata = 8'h22;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t4_busy_second", 32'(busy), 1);
        wait_rsp(lat);
        check("t4_latency2", 32'(lat), 80 * DIV);
        settle();
        check("t4_slave_data", 32'(s_data_in), 32'h22);
        check("t4_starts", 32'(n_start - b_start), 2);
        check("t4_stops", 32'(n_stop - b_stop), 2);
        check("t4_rsp_count", 32'(n_rsp - b_rsp), 2);

        // 5: reset during WDATA bit 3 (0xE7 -> that bit is 0)
        send(7'h50, 1'b0, 8'hE7);
        repeat (53 * DIV) @(negedge clk);
        check("t5_scl_low", 32'(scl), 0);
        check("t5_sda_low", 32'(sda), 0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_scl", 32'(scl), 1);
        check("t5_rst_sda", 32'(sda), 1);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        snap();
        send(7'h50, 1'b0, 8'h5A);
        wait_rsp(lat);
        check("t5_latency", 32'(lat), 80 * DIV);
        check("t5_nack", 32'(rsp_nack), 0);
        settle();
        check("t5_slave_data", 32'(s_data_in), 32'h5A);
        check("t5_starts", 32'(n_start - b_start), 1);

        check("scl_period_errors", 32'(per_err), 0);
        check("total_rsp", 32'(n_rsp), 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
